// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for mix_columns_seq: input state channel, result channel, status.
// Optional port: bypass, present when MIX_COLUMNS_BYPASS_EN is defined.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;
  logic         busy;
`ifdef MIX_COLUMNS_BYPASS_EN
  logic         bypass;
`endif

  // Producer/consumer side (drives states in, takes results out)
  modport master (
    output in_valid, in, mode, out_ready,
    input  in_ready, out_valid, out, busy
`ifdef MIX_COLUMNS_BYPASS_EN
    , output bypass
`endif
  );

  // Block side
  modport slave (
    input  in_valid, in, mode, out_ready,
    output in_ready, out_valid, out, busy
`ifdef MIX_COLUMNS_BYPASS_EN
    , input bypass
`endif
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns on a 128-bit state, COLS_PER_CYCLE
// columns per clock, valid/ready handshake on both sides.
// Optional feature macro: MIX_COLUMNS_BYPASS_EN (adds bypass, copies state unmixed).
module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst,
  mix_columns_seq_if.slave io_bus
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned N_STEPS = 4 / COLS_PER_CYCLE;

  // Reject unsupported column widths at elaboration
  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [STATE_W-1:0]   r_st;
  logic [STATE_W-1:0]   w_st_nxt;
  logic [STATE_W-1:0]   r_res;
  logic [STATE_W-1:0]   w_res_nxt;
  logic                 r_mode;
  logic                 w_mode_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_accept;
`ifdef MIX_COLUMNS_BYPASS_EN
  logic                 r_bypass;
  logic                 w_bypass_nxt;
`endif

  logic [CNT_W-1:0]     w_col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0]     w_col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]     w_col_mix [COLS_PER_CYCLE];

  // GF(2^8) multiply by x, reduced by 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gm9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // One column, forward or inverse; row-0 byte is the most significant
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    if (inv) begin
      r0 = gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3);
      r1 = gm9(a0)  ^ gm14(a1) ^ gm11(a2) ^ gm13(a3);
      r2 = gm13(a0) ^ gm9(a1)  ^ gm14(a2) ^ gm11(a3);
      r3 = gm11(a0) ^ gm13(a1) ^ gm9(a2)  ^ gm14(a3);
    end else begin
      r0 = xtime(a0) ^ gm3(a1)   ^ a2        ^ a3;
      r1 = a0        ^ xtime(a1) ^ gm3(a2)   ^ a3;
      r2 = a0        ^ a1        ^ xtime(a2) ^ gm3(a3);
      r3 = gm3(a0)   ^ a1        ^ a2        ^ xtime(a3);
    end
    return {r0, r1, r2, r3};
  endfunction

  // COLS_PER_CYCLE mixers, fed from the columns selected by the step counter (MSB column first)
  generate
    for (genvar k = 0; k < int'(COLS_PER_CYCLE); k++) begin : g_mix
      assign w_col_idx[k] = CNT_W'(3 - int'(r_cnt) * int'(COLS_PER_CYCLE) - k);
      assign w_col_in[k]  = r_st[32'(w_col_idx[k]) * COL_W +: COL_W];
      assign w_col_mix[k] = mix_col(w_col_in[k], r_mode);
    end
  endgenerate

  // Next-state and datapath-load decode
  always_comb begin
    w_state_nxt = r_state;
    w_st_nxt    = r_st;
    w_res_nxt   = r_res;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
`ifdef MIX_COLUMNS_BYPASS_EN
    w_bypass_nxt = r_bypass;
`endif

    case (r_state)
      S_IDLE: begin
        if (io_bus.in_valid) begin
          w_accept = 1'b1;
        end
      end
      S_BUSY: begin
`ifdef MIX_COLUMNS_BYPASS_EN
        if (r_bypass) begin
          w_res_nxt   = r_st;
          w_state_nxt = S_DONE;
        end else
`endif
        begin
          for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
            w_res_nxt[32'(w_col_idx[k]) * COL_W +: COL_W] = w_col_mix[k];
          end
          if (r_cnt == CNT_W'(N_STEPS - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (io_bus.out_ready) begin
          if (io_bus.in_valid) begin
            w_accept = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_accept) begin
      w_st_nxt    = io_bus.in;
      w_mode_nxt  = io_bus.mode;
      w_cnt_nxt   = '0;
      w_state_nxt = S_BUSY;
`ifdef MIX_COLUMNS_BYPASS_EN
      w_bypass_nxt = io_bus.bypass;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers; reset discards any partial result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= '0;
      r_res  <= '0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_st   <= w_st_nxt;
      r_res  <= w_res_nxt;
      r_mode <= w_mode_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

`ifdef MIX_COLUMNS_BYPASS_EN
  // Bypass flag, captured alongside mode at accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bypass <= 1'b0;
    end else begin
      r_bypass <= w_bypass_nxt;
    end
  end
`endif

  // Status decoded from the state register; in_ready passes out_ready through in DONE
  assign io_bus.in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && io_bus.out_ready);
  assign io_bus.out_valid = (r_state == S_DONE);
  assign io_bus.busy      = (r_state == S_BUSY);
  assign io_bus.out       = r_res;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench: three instances (1, 2, 4 columns/cycle) driven in lockstep,
// checked against a generic GF(2^8) matrix-multiply reference model.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         t_in_valid;
  logic [127:0] t_in;
  logic         t_mode;
  logic         t_out_ready;
`ifdef MIX_COLUMNS_BYPASS_EN
  logic         t_bypass;
`endif

  int n_chk = 0;
  int n_err = 0;

  localparam int CPC [3] = '{1, 2, 4};
  localparam int LAT [3] = '{4, 2, 1};

  always #5 clk = ~clk;

  mix_columns_seq_if u_if1 ();
  mix_columns_seq_if u_if2 ();
  mix_columns_seq_if u_if4 ();

  assign u_if1.in_valid = t_in_valid;  assign u_if2.in_valid = t_in_valid;  assign u_if4.in_valid = t_in_valid;
  assign u_if1.in = t_in;              assign u_if2.in = t_in;              assign u_if4.in = t_in;
  assign u_if1.mode = t_mode;          assign u_if2.mode = t_mode;          assign u_if4.mode = t_mode;
  assign u_if1.out_ready = t_out_ready; assign u_if2.out_ready = t_out_ready; assign u_if4.out_ready = t_out_ready;
`ifdef MIX_COLUMNS_BYPASS_EN
  assign u_if1.bypass = t_bypass;      assign u_if2.bypass = t_bypass;      assign u_if4.bypass = t_bypass;
`endif

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .io_bus(u_if1.slave));
  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .io_bus(u_if2.slave));
  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .io_bus(u_if4.slave));

  logic         w_ov [3];
  logic         w_ir [3];
  logic         w_bz [3];
  logic [127:0] w_out [3];
  assign w_ov[0] = u_if1.out_valid; assign w_ov[1] = u_if2.out_valid; assign w_ov[2] = u_if4.out_valid;
  assign w_ir[0] = u_if1.in_ready;  assign w_ir[1] = u_if2.in_ready;  assign w_ir[2] = u_if4.in_ready;
  assign w_bz[0] = u_if1.busy;      assign w_bz[1] = u_if2.busy;      assign w_bz[2] = u_if4.busy;
  assign w_out[0] = u_if1.out;      assign w_out[1] = u_if2.out;      assign w_out[2] = u_if4.out;

  // Reference: generic shift-and-add GF(2^8) multiply, matrix times column
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [8:0] t;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      t = {a, 1'b0};
      if (t[8]) t = t ^ 9'h11B;
      a = t[7:0];
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0] enc [4][4];
    logic [7:0] dec [4][4];
    logic [7:0] a [4];
    logic [7:0] acc;
    logic [127:0] r;
    enc = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
            '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    dec = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
            '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[c*32 + 24 - 8*j +: 8];
      for (int rw = 0; rw < 4; rw++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(inv ? dec[rw][j] : enc[rw][j], a[j]);
        r[c*32 + 24 - 8*rw +: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one state for one accept edge, then scramble the inputs
  task automatic accept(input logic [127:0] d, input logic md);
    t_in_valid = 1'b1;
    t_in       = d;
    t_mode     = md;
    step();
    t_in_valid = 1'b0;
    t_in       = {$urandom, $urandom, $urandom, $urandom};
    t_mode     = ~md;
  endtask

  // Wait (bounded) for all instances to finish; check latency and result
  task automatic collect(input string tag, input logic [127:0] exp, input int lat_ovr);
    int lat [3];
    bit all_done;
    lat = '{0, 0, 0};
    for (int cyc = 1; cyc <= 8; cyc++) begin
      step();
      t_in_valid = 1'($urandom_range(0, 1));
      t_in       = {$urandom, $urandom, $urandom, $urandom};
      all_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (w_ov[i] && lat[i] == 0) lat[i] = cyc;
        if (lat[i] == 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
    t_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s/cpc%0d latency", tag, CPC[i]), 128'(lat[i]),
          128'(lat_ovr > 0 ? lat_ovr : LAT[i]));
      chk($sformatf("%s/cpc%0d out", tag, CPC[i]), w_out[i], exp);
    end
  endtask

  // Take the result with out_ready for one cycle; blocks return to IDLE
  task automatic retire(input string tag);
    t_out_ready = 1'b1;
    t_in_valid  = 1'b0;
    step();
    t_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s/cpc%0d idle out_valid", tag, CPC[i]), 128'(w_ov[i]), 128'(0));
      chk($sformatf("%s/cpc%0d idle in_ready", tag, CPC[i]), 128'(w_ir[i]), 128'(1));
    end
  endtask

  typedef struct {
    logic [127:0] din;
    logic         md;
    logic [127:0] dout;
  } vec_t;

  initial begin
    vec_t         tbl [4];
    logic [127:0] d;
    logic [127:0] held [3];
    logic         md;

    tbl[0] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c};
    tbl[1] = '{128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    tbl[2] = '{{32'hdb135345, 96'h0}, 1'b0, {32'h8e4da1bc, 96'h0}};
    tbl[3] = '{{32'h8e4da1bc, 96'h0}, 1'b1, {32'hdb135345, 96'h0}};

    rst = 1'b1;
    t_in_valid = 1'b0;
    t_in = '0;
    t_mode = 1'b0;
    t_out_ready = 1'b0;
`ifdef MIX_COLUMNS_BYPASS_EN
    t_bypass = 1'b0;
`endif
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset/cpc%0d in_ready", CPC[i]), 128'(w_ir[i]), 128'(1));
      chk($sformatf("reset/cpc%0d out_valid", CPC[i]), 128'(w_ov[i]), 128'(0));
      chk($sformatf("reset/cpc%0d busy", CPC[i]), 128'(w_bz[i]), 128'(0));
      chk($sformatf("reset/cpc%0d out", CPC[i]), w_out[i], 128'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    step();

    // Known-answer vectors
    for (int v = 0; v < 4; v++) begin
      accept(tbl[v].din, tbl[v].md);
      for (int i = 0; i < 3; i++)
        chk($sformatf("vec%0d/cpc%0d busy", v, CPC[i]), 128'(w_bz[i]), 128'(1));
      collect($sformatf("vec%0d", v), tbl[v].dout, 0);
      retire($sformatf("vec%0d", v));
    end

    // Random states against the reference model
    for (int n = 0; n < 20; n++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      md = 1'($urandom_range(0, 1));
      accept(d, md);
      collect($sformatf("rnd%0d", n), ref_mix(d, md), 0);
      retire($sformatf("rnd%0d", n));
    end

    // Backpressure in DONE, then same-edge retire and accept
    d = {$urandom, $urandom, $urandom, $urandom};
    accept(d, 1'b0);
    collect("bp", ref_mix(d, 1'b0), 0);
    for (int i = 0; i < 3; i++) held[i] = w_out[i];
    for (int c = 0; c < 5; c++) begin
      t_in_valid = 1'b1;
      t_in = {$urandom, $urandom, $urandom, $urandom};
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bp%0d/cpc%0d in_ready", c, CPC[i]), 128'(w_ir[i]), 128'(0));
        chk($sformatf("bp%0d/cpc%0d out", c, CPC[i]), w_out[i], held[i]);
        chk($sformatf("bp%0d/cpc%0d out_valid", c, CPC[i]), 128'(w_ov[i]), 128'(1));
      end
      step();
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    t_out_ready = 1'b1;
    t_in = d;
    t_mode = 1'b1;
    t_in_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("handoff/cpc%0d in_ready", CPC[i]), 128'(w_ir[i]), 128'(1));
    step();
    t_out_ready = 1'b0;
    t_in_valid = 1'b0;
    t_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("handoff/cpc%0d busy", CPC[i]), 128'(w_bz[i]), 128'(1));
      chk($sformatf("handoff/cpc%0d out_valid", CPC[i]), 128'(w_ov[i]), 128'(0));
    end
    collect("handoff", ref_mix(d, 1'b1), 0);
    retire("handoff");

    // Reset after the second BUSY cycle aborts everything immediately
    accept({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    step();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort/cpc%0d out", CPC[i]), w_out[i], 128'h0);
      chk($sformatf("abort/cpc%0d out_valid", CPC[i]), 128'(w_ov[i]), 128'(0));
      chk($sformatf("abort/cpc%0d in_ready", CPC[i]), 128'(w_ir[i]), 128'(1));
      chk($sformatf("abort/cpc%0d busy", CPC[i]), 128'(w_bz[i]), 128'(0));
    end
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    accept(tbl[0].din, 1'b0);
    collect("post_abort", tbl[0].dout, 0);
    retire("post_abort");

`ifdef MIX_COLUMNS_BYPASS_EN
    // Bypass copies the state unchanged in one cycle
    t_bypass = 1'b1;
    accept(128'h0123456789abcdeffedcba9876543210, 1'b0);
    t_bypass = 1'b0;
    collect("bypass", 128'h0123456789abcdeffedcba9876543210, 1);
    retire("bypass");
    accept(tbl[0].din, 1'b0);
    collect("post_bypass", tbl[0].dout, 0);
    retire("post_bypass");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
